fpmul_stream_ctrl: RTL and testbench
====================================

// Module: fpmul_stream_ctrl
// PURPOSE
//  Flow-control front/back end for the free-running 4-stage FPmul pipeline, which has no valid/ready.
//  Accepts operand pairs on a valid/ready input channel and drives them onto FPmul FP_A/FP_B.
//  Tracks which pipeline slots hold real work and captures FP_Z into a result FIFO.
//  Presents results on a valid/ready output channel, with credit-based backpressure so no result is lost.
// PARAMETERS
//  MUL_LAT     4   cycles from FP_A/FP_B sampled at an edge to matching FP_Z (FPmul pipeline depth)
//  FIFO_DEPTH  8   result FIFO entries; must be >= MUL_LAT; power of two
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   controller can accept a pair this cycle
//  in_a       in   32  IEEE-754 single operand A
//  in_b       in   32  IEEE-754 single operand B
//  mul_a      out  32  to FPmul FP_A
//  mul_b      out  32  to FPmul FP_B
//  mul_z      in   32  from FPmul FP_Z
//  out_valid  out  1   result available at out_z
//  out_ready  in   1   consumer takes result this cycle
//  out_z      out  32  product, in issue order
//  busy       out  1   work in flight or results pending
// BEHAVIOUR
//  - fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
//  - mul_a/mul_b = in_a/in_b when fire_in, else 32'h0. Combinational; FPmul registers them.
//  - vld_sr[MUL_LAT-1:0] shift register: vld_sr[0] <= fire_in, vld_sr[i] <= vld_sr[i-1] each cycle.
//    vld_sr[MUL_LAT-1]=1 means mul_z holds a real product this cycle; it is pushed to the FIFO.
//  - inflight = popcount(vld_sr) as a counter: +1 on fire_in, -1 on push; both in one cycle -> unchanged.
//  - Credit: in_ready = (inflight + fifo_cnt) < FIFO_DEPTH, computed from registered state only.
//    in_ready does not depend on out_ready or in_valid (no combinational path in->out).
//    Overflow is impossible by construction. A push with fifo full is an assertion failure.
//  - FIFO is first-word-fall-through: out_valid = (fifo_cnt!=0), out_z = head entry.
//    When not valid, out_z holds its last value (0 after reset).
//  - Push and pop in the same cycle: fifo_cnt unchanged; pointers advance mod FIFO_DEPTH.
//  - Push to an empty FIFO: visible at out_z the next cycle. No bypass; minimum latency is MUL_LAT+1 from fire_in.
//  - Throughput: 1 pair/cycle sustained while out_ready=1.
//  - out_valid=1 and out_z are held stable until fire_out. No ordering change, no drops.
//  - busy = (inflight!=0) | (fifo_cnt!=0).
//  - Reset (any time, including mid-operation): vld_sr, inflight, fifo_cnt, rd/wr pointers <= 0.
//    out_valid=0, out_z=0, in_ready=1 the cycle after rst deasserts, busy=0.
//    Products still inside FPmul at reset are discarded because their vld_sr bits are cleared.
//    FPmul itself has no reset, so garbage on mul_z is ignored.
//  - Arithmetic is FPmul's own; this block never inspects or alters data bits.
//    NaN, Inf and zero pass through untouched.
// TESTING (bench instantiates fpmul_stream_ctrl + FPmul)
//  1. Single op: A=0x40000000 (2.0), B=0x40400000 (3.0), out_ready=1
//     -> out_valid at fire_in+5, out_z=0x40C00000; busy falls next cycle.
//  2. Streaming: 16 back-to-back pairs (1.5*1.5=0x3FC00000 each) with out_ready=1
//     -> in_ready never drops; 16 results 0x40100000 on consecutive cycles, in order.
//  3. Backpressure: out_ready=0, in_valid=1 continuously -> exactly 8 accepted; in_ready=0 after the 8th.
//     Then out_ready=1 -> 8 results drain in order, then in_ready rises.
//  4. Simultaneous push/pop with FIFO full at 8: out_ready=1 for one cycle
//     -> one credit frees and one new pair is accepted the next cycle; fifo_cnt never exceeds 8.
//  5. Reset mid-flight: 3 pairs issued, rst pulsed 1 cycle at fire+2
//     -> no out_valid ever for those pairs; busy=0, in_ready=1 after reset.
//  6. Specials: 0x7F800000*0x00000000 -> out_z=0x7FC00000-class NaN, exactly as FPmul yields.
//     Random out_ready toggling over 1000 ops -> scoreboard matches, zero loss or duplication.

Source files
------------

// File: rtl/fpmul_stream_ctrl.sv
// Valid/ready wrapper around the free-running FPmul pipeline: issues operand pairs,
// tracks real work through the pipe and buffers products in a credit-guarded FWFT FIFO.
module fpmul_stream_ctrl #(
  parameter int MUL_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        busy
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MUL_LAT + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

  logic [MUL_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [INF_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]        hold_z_q, hold_z_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [SUM_W-1:0]   credit_used;
  logic               fire_in, fire_out, push;

  // Every accepted pair reserves a FIFO slot until it is popped, so a push can never find the FIFO full.
  assign credit_used = SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q);
  assign in_ready    = credit_used < SUM_W'(FIFO_DEPTH);
  assign out_valid   = fifo_cnt_q != '0;
  assign out_z       = out_valid ? mem_q[rd_ptr_q] : hold_z_q;
  assign busy        = (inflight_q != '0) | (fifo_cnt_q != '0);

  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;
  assign push     = vld_sr_q[MUL_LAT-1];

  // Idle cycles feed zeros so the pipe never sees stale operands.
  assign mul_a = fire_in ? in_a : 32'h0;
  assign mul_b = fire_in ? in_b : 32'h0;

  always_comb begin
    vld_sr_d   = {vld_sr_q[MUL_LAT-2:0], fire_in};
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_z_d   = hold_z_q;

    case ({fire_in, push})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({push, fire_out})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (fire_out) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      hold_z_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_z_q   <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_z_q   <= hold_z_d;
    end
  end

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= mul_z;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fpmul_stream_ctrl.sv
// Bench for fpmul_stream_ctrl with a 4-stage FPmul stand-in; a queue of accepted,
// not-yet-delivered products predicts in_ready, out_valid, out_z and busy every cycle.
module tb_fpmul_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mul_a, mul_b, mul_z;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  fpmul_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply; denormals flush to zero, NaN results are 0x7FC00000.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] m;
    logic [22:0] frac;
    int          e;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = a[30:23] == 8'h00;
    b_zero = b[30:23] == 8'h00;
    if (a_nan || b_nan) return 32'h7FC00000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      frac = m[46:24];
      e    = e + 1;
    end else begin
      frac = m[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], frac};
  endfunction

  logic [31:0] p0, p1, p2, p3;
  always @(posedge clk) begin
    p0 <= fp_mul(mul_a, mul_b);
    p1 <= p0;
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_z = p3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] z;
    int          t;
  } ent_t;

  ent_t        q[$];
  logic [31:0] last_z = 32'h0;
  logic [31:0] last_out = 32'h0;
  int          cyc = 0;
  int          n_in = 0, n_out = 0;
  int          last_in_cyc = 0, last_out_cyc = 0;

  // q holds every pair accepted in an earlier cycle and not yet popped; it becomes visible 5 cycles after acceptance.
  always @(negedge clk) begin
    logic        exp_valid;
    logic [31:0] exp_z;
    if (rst) begin
      q.delete();
      last_z = 32'h0;
    end else begin
      exp_valid = (q.size() != 0) && (cyc >= q[0].t + 5);
      exp_z     = exp_valid ? q[0].z : last_z;
      chk("in_ready", 32'(in_ready), 32'(q.size() < 8));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_z", out_z, exp_z);
      chk("mul_a", mul_a, (in_valid && in_ready) ? in_a : 32'h0);
      chk("mul_b", mul_b, (in_valid && in_ready) ? in_b : 32'h0);
      if (out_valid && out_ready && q.size() != 0) begin
        last_z = q[0].z;
        void'(q.pop_front());
        last_out     = out_z;
        last_out_cyc = cyc;
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{z: fp_mul(in_a, in_b), t: cyc});
        last_in_cyc = cyc;
        n_in++;
      end
    end
    cyc++;
  end

  int stalls = 0;

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int w;
    w        = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      stalls++;
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < budget) begin
      w++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(9))
      0: r = {r[31], 31'h0};
      1: r = {r[31], 8'hFF, 23'h0};
      2: r = {r[31], 8'hFF, r[22:0] | 23'h1};
      3: r = {r[31], 8'h7F, r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  int b_in, b_out, k;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out_z", out_z, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;

    send(32'h40000000, 32'h40400000);
    wait_idle(50);
    chk("single_z", last_out, 32'h40C00000);
    chk("single_latency", 32'(last_out_cyc - last_in_cyc), 32'd5);

    b_out  = n_out;
    stalls = 0;
    for (int i = 0; i < 16; i++) send(32'h3FC00000, 32'h3FC00000);
    wait_idle(50);
    chk("stream_count", 32'(n_out - b_out), 32'd16);
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_z", last_out, 32'h40100000);

    b_in      = n_in;
    b_out     = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = rand_op();
      in_b = rand_op();
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 32'(n_in - b_in), 32'd8);
    chk("bp_ready_low", 32'(in_ready), 32'h0);
    chk("bp_no_out", 32'(n_out - b_out), 32'd0);

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("full_swap_in", 32'(n_in - b_in), 32'd9);
    chk("full_swap_out", 32'(n_out - b_out), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(100);
    chk("bp_drain", 32'(n_out - b_out), 32'd9);

    b_out = n_out;
    send(32'h40000000, 32'h40000000);
    send(32'h3FC00000, 32'h40400000);
    send(32'h40400000, 32'h40400000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid_out", 32'(n_out - b_out), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ready", 32'(in_ready), 32'h1);
    chk("rst_mid_hold", out_z, 32'h0);

    send(32'h7F800000, 32'h00000000);
    wait_idle(50);
    chk("inf_times_zero", last_out, 32'h7FC00000);

    b_in  = n_in;
    b_out = n_out;
    k     = 0;
    while ((n_in - b_in) < 1000 && k < 30000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = $urandom_range(1) == 1;
      @(posedge clk);
      #1;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(200);
    chk("rand_in", 32'(n_in - b_in), 32'd1000);
    chk("rand_out", 32'(n_out - b_out), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
